// File: rtl/comm_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers.
// AW and W are accepted independently; BVALID and RVALID are single outstanding responses.
module comm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic [3:0][DW-1:0] regs_q, regs_d;
  logic               rdy_en_q, rdy_en_d;
  logic               aw_held_q, aw_held_d;
  logic               w_held_q, w_held_d;
  logic [1:0]         aw_idx_q, aw_idx_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [SW-1:0]      wstrb_q, wstrb_d;
  logic               bvalid_q, bvalid_d;
  logic               rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [3:0]         wr_pulse_q, wr_pulse_d;

  logic               aw_hs, w_hs, ar_hs, wr_commit;
  logic [1:0]         wr_idx;
  logic [DW-1:0]      wr_data;
  logic [SW-1:0]      wr_strb;
  logic               unused_ok;

  // Readies stay low through reset and rise on the first edge after release.
  assign S_AXI_AWREADY = rdy_en_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = rdy_en_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = rdy_en_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign slv_reg0      = regs_q[0];
  assign slv_reg1      = regs_q[1];
  assign slv_reg2      = regs_q[2];
  assign slv_reg3      = regs_q[3];
  assign reg_wr_pulse  = wr_pulse_q;
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    wr_idx    = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
    wr_data   = w_held_q ? wdata_q : S_AXI_WDATA;
    wr_strb   = w_held_q ? wstrb_q : S_AXI_WSTRB;
    wr_commit = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

    rdy_en_d   = 1'b1;
    regs_d     = regs_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    wr_pulse_d = '0;

    if (wr_commit) begin
      for (int i = 0; i < SW; i++)
        if (wr_strb[i]) regs_d[wr_idx][8*i +: 8] = wr_data[8*i +: 8];
      aw_held_d          = 1'b0;
      w_held_d           = 1'b0;
      bvalid_d           = 1'b1;
      wr_pulse_d[wr_idx] = 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end
      if (bvalid_q & S_AXI_BREADY) bvalid_d = 1'b0;
    end

    // Read samples regs_q, so a same-edge write to the same register returns the old value.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q & S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_q     <= '0;
      rdy_en_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rdy_en_q   <= rdy_en_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end
endmodule

// File: tb/tb_comm_axil_regs.sv
// Directed bench for comm_axil_regs: inputs driven and outputs checked on the falling edge.
module tb_comm_axil_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, r0, r1, r2, r3;
  logic [3:0]  pulse;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  comm_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .slv_reg0(r0), .slv_reg1(r1), .slv_reg2(r2), .slv_reg3(r3), .reg_wr_pulse(pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slv(input int idx);
    case (idx)
      0:       return r0;
      1:       return r1;
      2:       return r2;
      default: return r3;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents AW and W together; returns on the falling edge after the commit edge.
  task automatic axi_write(input string tag, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit do_b);
    bit awd = 0, wd = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awd && wd) && n < 20) begin
      if (awvalid && awready) awd = 1;
      if (wvalid && wready) wd = 1;
      cyc();
      n++;
      if (awd) awvalid = 1'b0;
      if (wd) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    chk({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
    chk({tag, "_pulse"}, {28'd0, pulse}, 32'd1 << a[3:2]);
    if (do_b) begin
      bready = 1'b1;
      cyc();
      bready = 1'b0;
      chk({tag, "_bclr"}, {31'd0, bvalid}, 32'd0);
    end
  endtask

  task automatic axi_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bit done = 0;
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!done && n < 20) begin
      if (arready) done = 1;
      cyc();
      n++;
    end
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk({tag, "_rclr"}, {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    logic [31:0] vals [4];
    vals = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    // Reset state and ready release
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_reg0", r0, 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_awready_low", {31'd0, awready}, 32'd0);
    cyc();
    chk("rel_ready", {29'd0, awready, wready, arready}, 32'h7);

    // Basic write/read of all four registers
    for (int i = 0; i < 4; i++) axi_write($sformatf("wr%0d", i), 4'(i * 4), vals[i], 4'hF, 1);
    for (int i = 0; i < 4; i++) begin
      axi_read($sformatf("rd%0d", i), 4'(i * 4), vals[i]);
      chk($sformatf("slv%0d", i), slv(i), vals[i]);
    end

    // Byte strobes; WSTRB=0 still responds
    axi_write("strb5", 4'h4, 32'h11223344, 4'b0101, 1);
    axi_read("strb5_rd", 4'h4, 32'hAB220044);
    axi_write("strb0", 4'h5, 32'hFFFFFFFF, 4'b0000, 1);
    chk("strb0_reg1", r1, 32'hAB220044);

    // W three cycles ahead of AW
    wdata = 32'h13572468; wstrb = 4'hF; wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    chk("wfirst_wready", {31'd0, wready}, 32'd0);
    chk("wfirst_nob", {31'd0, bvalid}, 32'd0);
    cyc(); cyc();
    chk("wfirst_reg2_old", r2, 32'hDEAD0011);
    awaddr = 4'h8; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    chk("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wfirst_pulse", {28'd0, pulse}, 32'h4);
    chk("wfirst_reg2", r2, 32'h13572468);
    bready = 1'b1; cyc(); bready = 1'b0;

    // BREADY held low: no new write until the response is taken
    axi_write("bhold", 4'hC, 32'h12345678, 4'hF, 0);
    awaddr = 4'hC; wdata = 32'h9ABCDEF0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bhold_bv%0d", k), {31'd0, bvalid}, 32'd1);
      chk($sformatf("bhold_rdy%0d", k), {30'd0, awready, wready}, 32'd0);
      if (k > 0) chk($sformatf("bhold_pulse%0d", k), {28'd0, pulse}, 32'd0);
      cyc();
    end
    chk("bhold_reg3", r3, 32'h12345678);
    bready = 1'b1; cyc(); bready = 1'b0;
    chk("bhold_bclr", {31'd0, bvalid}, 32'd0);
    chk("bhold_rdy_back", {30'd0, awready, wready}, 32'h3);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bhold_2nd_bv", {31'd0, bvalid}, 32'd1);
    chk("bhold_2nd_reg3", r3, 32'h9ABCDEF0);
    chk("bhold_2nd_pulse", {28'd0, pulse}, 32'h8);
    bready = 1'b1; cyc(); bready = 1'b0;

    // Same-edge write and read of reg0
    awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_rdata_old", rdata, 32'h0101FFFF);
    chk("rw_reg0_new", r0, 32'h5);
    bready = 1'b1; rready = 1'b1; cyc(); bready = 1'b0; rready = 1'b0;
    axi_read("rw_rd", 4'h0, 32'h5);

    // Reset with AW held and a read response pending
    awaddr = 4'h4; awvalid = 1'b1; araddr = 4'h4; arvalid = 1'b1;
    cyc();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("mrst_pre_rv", {31'd0, rvalid}, 32'd1);
    chk("mrst_pre_awheld", {31'd0, awready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", {29'd0, awready, wready, arready}, 32'd0);
    chk("mrst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    chk("mrst_rdata", rdata, 32'd0);
    chk("mrst_regs", r0 | r1 | r2 | r3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    chk("mrst_no_commit_bv", {31'd0, bvalid}, 32'd0);
    chk("mrst_no_commit_reg1", r1, 32'd0);
    chk("mrst_w_held", {31'd0, wready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comm_axil_regs.md
COMM_AXIL_REGS -- requirements
Module: comm_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI byte-address width.
REQ-003 SHALL have port S_AXI_ACLK  in  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write-address channel.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write-data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write-response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read-address channel.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read-data channel.
REQ-010 SHALL have ports slv_reg0..slv_reg3 out 32 each (current register contents) and reg_wr_pulse out 4 (per-register write strobe).

Function
REQ-011 SHALL implement four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8, 0xC, selected by addr[3:2]; addr[1:0] and AxPROT ignored.
REQ-012 SHALL accept AW and W independently in any order: AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID; a handshake on a channel without its partner sets the matching held flag and captures addr/data+strb.
REQ-013 SHALL commit a write at the first edge where address and data are both available (held or handshaking that edge) and BVALID is low; at that edge the selected register updates, both held flags clear, BVALID sets.
REQ-014 Latency: AW and W handshaking at the same edge N -> register value and BVALID visible after edge N (zero idle cycles).
REQ-015 SHALL apply WSTRB per byte: lane i updates bits [8i+7:8i] only when WSTRB[i]=1; WSTRB=0000 commits no change but still returns a response.
REQ-016 BRESP and RRESP SHALL always be 2'b00 (OKAY).
REQ-017 BVALID SHALL stay high until the edge with BREADY=1, then clear; no new AW/W accepted while BVALID high.
REQ-018 ARREADY = !RVALID; AR handshake at edge N -> RVALID high and RDATA = selected register after edge N; RDATA/RVALID stable until RREADY=1 edge, then RVALID clears.
REQ-019 Read and write of the same register committing at the same edge SHALL return the pre-write value.
REQ-020 reg_wr_pulse[k] SHALL be high for exactly one cycle, the cycle BVALID first rises for a write to register k (including WSTRB=0000).
REQ-021 slv_regN outputs SHALL reflect register contents directly (registered, no extra latency).

Reset
REQ-022 ARESETN low SHALL asynchronously clear all registers to 0x00000000, AWREADY/WREADY/ARREADY/BVALID/RVALID/reg_wr_pulse to 0, held flags to 0, RDATA to 0.
REQ-023 Ready outputs SHALL be 0 while in reset and rise at the first clock edge after deassertion.
REQ-024 Reset mid-transaction SHALL abandon any held AW/W and pending B/R response; no partial write is committed.

Verification
REQ-025 After reset, write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0/0x4/0x8/0xC, read each back -> RDATA equals written value, BRESP=RRESP=00, slv_reg0..3 match.
REQ-026 Reg1=0xABCD0001, write 0x11223344 with WSTRB=0101 -> read 0xAB220044; WSTRB=0000 -> value unchanged, BVALID still returned.
REQ-027 W handshake 3 cycles before AW to 0x8 -> WREADY low after W, write commits at AW edge, reg2 and reg_wr_pulse[2] update together.
REQ-028 Hold BREADY low 5 cycles after write -> BVALID held, AWREADY/WREADY low; second write accepted only after BREADY handshake.
REQ-029 Write 0x5 and read reg0 (old 0x0101FFFF) commit same edge -> RDATA 0x0101FFFF, subsequent read 0x00000005.
REQ-030 Assert ARESETN low with AW held and RVALID pending -> all outputs 0 immediately, reg contents 0, no write committed after release.
